// File: rtl/datapath_control_sequencer_if.sv
// Control bundle between the sequencer (master) and the 32-bit bus datapath (slave).
// STEP_MODE_EN adds the Step input used for single-instruction stepping.
interface datapath_control_sequencer_if #(
    parameter int NREGS = 16,
    parameter int OPW   = 5
);
    logic             Run;
    logic [31:0]      IR;
    logic             Mem_ready;
`ifdef STEP_MODE_EN
    logic             Step;
`endif
    logic             PCout, Zlowout, ZHighout, MDRout;
    logic             MARin, PCin, MDRin, IRin, Yin, Zin, LOin, HIin;
    logic             IncPC, Read, Halted, Illegal;
    logic [NREGS-1:0] Rin, Rout;
    logic [OPW-1:0]   operation;

    modport master (
        input  Run, IR, Mem_ready,
`ifdef STEP_MODE_EN
               Step,
`endif
        output PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin,
               LOin, HIin, IncPC, Read, Halted, Illegal, Rin, Rout, operation
    );

    modport slave (
        output Run, IR, Mem_ready,
`ifdef STEP_MODE_EN
               Step,
`endif
        input  PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin,
               LOin, HIin, IncPC, Read, Halted, Illegal, Rin, Rout, operation
    );
endinterface

// File: rtl/datapath_control_sequencer.sv
// Hardwired Moore control unit: fetch / decode / execute, one control step per Clock.
// Define STEP_MODE_EN to stop in IDLE after each instruction until a Step rising edge.
module datapath_control_sequencer #(
    parameter int NREGS = 16,
    parameter int OPW   = 5
) (
    input logic Clock,
    input logic Reset_n,
    datapath_control_sequencer_if.master bus
);
    localparam int RW = $clog2(NREGS);
    localparam logic [NREGS-1:0] ONE = {{(NREGS-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5A, S_T5M, S_T6, S_HALT
    } state_t;

    state_t        r_state, w_next, w_done;
    logic          r_illegal;
    logic [4:0]    w_op;
    logic [RW-1:0] w_ra, w_rb, w_rc;
    logic          w_alu, w_md, w_nop, w_halt, w_bad, w_go;
    logic          w_unused_ir;

    // Register fields wider than the file are masked to their low bits.
    assign w_op   = bus.IR[31:27];
    assign w_ra   = bus.IR[23 +: RW];
    assign w_rb   = bus.IR[19 +: RW];
    assign w_rc   = bus.IR[15 +: RW];
    assign w_unused_ir = ^bus.IR[14:0];

    assign w_alu  = (w_op <= 5'd14);
    assign w_md   = (w_op == 5'd15) || (w_op == 5'd16);
    assign w_nop  = (w_op == 5'd26);
    assign w_halt = (w_op == 5'd27);
    assign w_bad  = ~(w_alu | w_md | w_nop | w_halt);

`ifdef STEP_MODE_EN
    logic r_step_d;
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) r_step_d <= 1'b0;
        else          r_step_d <= bus.Step;
    end
    assign w_go   = bus.Run & bus.Step & ~r_step_d;
    assign w_done = S_IDLE;
`else
    assign w_go   = bus.Run;
    assign w_done = bus.Run ? S_T0 : S_IDLE;
`endif

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= S_IDLE;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_T3 && w_bad) r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_go) w_next = S_T0;
            S_T0:   w_next = S_T1;
            S_T1,
            S_T1W:  w_next = bus.Mem_ready ? S_T2 : S_T1W;
            S_T2:   w_next = S_T3;
            S_T3: begin
                if (w_alu || w_md) w_next = S_T4;
                else if (w_halt)   w_next = S_HALT;
                else               w_next = w_done;
            end
            S_T4:   w_next = w_md ? S_T5M : S_T5A;
            S_T5A:  w_next = w_done;
            S_T5M:  w_next = S_T6;
            S_T6:   w_next = w_done;
            S_HALT: w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.Illegal = r_illegal;

    // Only one bus driver per state keeps the shared bus contention-free.
    always_comb begin
        bus.PCout = 1'b0; bus.Zlowout = 1'b0; bus.ZHighout = 1'b0; bus.MDRout = 1'b0;
        bus.MARin = 1'b0; bus.PCin = 1'b0; bus.MDRin = 1'b0; bus.IRin = 1'b0;
        bus.Yin = 1'b0; bus.Zin = 1'b0; bus.LOin = 1'b0; bus.HIin = 1'b0;
        bus.IncPC = 1'b0; bus.Read = 1'b0; bus.Halted = 1'b0;
        bus.Rin = '0; bus.Rout = '0; bus.operation = '0;
        case (r_state)
            S_T0:  begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1; end
            S_T1:  begin bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1; end
            S_T1W: begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
            S_T2:  begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
            S_T3: begin
                if (w_alu || w_md) begin
                    bus.Rout = ONE << w_rb;
                    bus.Yin  = 1'b1;
                end
            end
            S_T4: begin
                bus.Rout      = ONE << w_rc;
                bus.Zin       = 1'b1;
                bus.operation = OPW'(w_op);
            end
            S_T5A:  begin bus.Zlowout = 1'b1; bus.Rin = ONE << w_ra; end
            S_T5M:  begin bus.Zlowout = 1'b1; bus.LOin = 1'b1; end
            S_T6:   begin bus.ZHighout = 1'b1; bus.HIin = 1'b1; end
            S_HALT: bus.Halted = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_datapath_control_sequencer.sv
// Bench for datapath_control_sequencer: directed vector table, hand-written corner
// sequences and randomized instructions against a per-cycle behavioural model.
`timescale 1ns/1ps
module tb_datapath_control_sequencer;
    localparam int NREGS = 16;
    localparam int OPW   = 5;
`ifdef STEP_MODE_EN
    localparam bit STEPM = 1'b1;
`else
    localparam bit STEPM = 1'b0;
`endif

    logic Clock = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clock = ~Clock;

    datapath_control_sequencer_if #(.NREGS(NREGS), .OPW(OPW)) bus ();
    datapath_control_sequencer #(.NREGS(NREGS), .OPW(OPW)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .bus(bus)
    );

    typedef struct packed {
        logic PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin;
        logic Yin, Zin, LOin, HIin, IncPC, Read, Halted, Illegal;
        logic [NREGS-1:0] Rin, Rout;
        logic [OPW-1:0]   op;
    } ov_t;

    typedef struct {
        bit          run, mr, step;
        logic [31:0] ir;
        ov_t         exp;
        logic [31:0] tag;
    } cyc_t;

    typedef struct {
        logic [31:0] ir;
        int          waits;
        logic [15:0] r3, rin;
        logic [4:0]  op;
        int          pcin, rw, hi;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    cyc_t q[$];
    ov_t  obs[$];
    bit   m_ill, m_idle;

    function automatic ov_t sample();
        ov_t s;
        s = {bus.PCout, bus.Zlowout, bus.ZHighout, bus.MDRout, bus.MARin, bus.PCin,
             bus.MDRin, bus.IRin, bus.Yin, bus.Zin, bus.LOin, bus.HIin, bus.IncPC,
             bus.Read, bus.Halted, bus.Illegal, bus.Rin, bus.Rout, bus.operation};
        return s;
    endfunction

    task automatic check_ov(input logic [31:0] name, input ov_t act, input ov_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t outputs act=%h exp=%h", name, $time, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model: expected outputs per control step ----------------
    function automatic ov_t base();
        ov_t e = '0;
        e.Illegal = m_ill;
        return e;
    endfunction

    function automatic bit rbit();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic void push(bit run, bit mr, bit step, logic [31:0] ir, ov_t e, logic [31:0] tag);
        cyc_t c;
        c.run = run; c.mr = mr; c.step = step; c.ir = ir; c.exp = e; c.tag = tag;
        q.push_back(c);
    endfunction

    function automatic void model_instr(logic [31:0] ir, int waits, bit run_end, bit rnd_mid, bit sh);
        ov_t e;
        int  op = int'(ir[31:27]);
        int  ra = int'(ir[26:23]) % NREGS;
        int  rb = int'(ir[22:19]) % NREGS;
        int  rc = int'(ir[18:15]) % NREGS;
        bit  alu = (op <= 14);
        bit  md  = (op == 15) || (op == 16);
        bit  nop = (op == 26);
        bit  hlt = (op == 27);
        bit  bad = !(alu || md || nop || hlt);
        if (m_idle) begin
            e = base();
            push(1'b0, rbit(), 1'b0, ir, e, "IDLE");
            push(1'b1, rbit(), 1'b1, ir, e, "LNCH");
        end
        e = base(); e.PCout = 1; e.MARin = 1; e.IncPC = 1; e.Zin = 1;
        push(rnd_mid ? rbit() : 1'b1, rbit(), sh, ir, e, "T0");
        e = base(); e.Zlowout = 1; e.PCin = 1; e.Read = 1; e.MDRin = 1;
        push(rnd_mid ? rbit() : 1'b1, waits == 0, sh, ir, e, "T1");
        for (int i = 0; i < waits; i++) begin
            e = base(); e.Read = 1; e.MDRin = 1;
            push(rnd_mid ? rbit() : 1'b1, i == waits - 1, sh, ir, e, "T1W");
        end
        e = base(); e.MDRout = 1; e.IRin = 1;
        push(rnd_mid ? rbit() : 1'b1, rbit(), sh, ir, e, "T2");
        e = base();
        if (alu || md) begin e.Rout[rb] = 1'b1; e.Yin = 1; end
        push((nop || bad) ? run_end : (rnd_mid ? rbit() : 1'b1), rbit(), sh, ir, e, "T3");
        if (bad) m_ill = 1'b1;
        if (hlt) begin m_idle = 1'b0; return; end
        if (nop || bad) begin m_idle = !run_end || STEPM; return; end
        e = base(); e.Rout[rc] = 1'b1; e.Zin = 1; e.op = OPW'(op);
        push(rnd_mid ? rbit() : 1'b1, rbit(), sh, ir, e, "T4");
        if (alu) begin
            e = base(); e.Zlowout = 1; e.Rin[ra] = 1'b1;
            push(run_end, rbit(), sh, ir, e, "T5");
        end else begin
            e = base(); e.Zlowout = 1; e.LOin = 1;
            push(rnd_mid ? rbit() : 1'b1, rbit(), sh, ir, e, "T5");
            e = base(); e.ZHighout = 1; e.HIin = 1;
            push(run_end, rbit(), sh, ir, e, "T6");
        end
        m_idle = !run_end || STEPM;
    endfunction

    function automatic void model_halt(int n, logic [31:0] ir);
        ov_t e;
        for (int i = 0; i < n; i++) begin
            e = base(); e.Halted = 1;
            push(rbit(), rbit(), rbit(), ir, e, "HALT");
        end
    endfunction

    // ---------------- stimulus application ----------------
    task automatic step_cyc(input cyc_t c);
        ov_t a;
        bus.Run = c.run; bus.Mem_ready = c.mr; bus.IR = c.ir;
`ifdef STEP_MODE_EN
        bus.Step = c.step;
`endif
        #1;
        a = sample();
        obs.push_back(a);
        check_ov(c.tag, a, c.exp);
    endtask

    task automatic play(input int n);
        for (int k = 0; k < n && q.size() > 0; k++) begin
            step_cyc(q.pop_front());
            @(posedge Clock); #2;
        end
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        #1;
        check_ov("RST", sample(), '0);
        q.delete(); m_ill = 1'b0; m_idle = 1'b1;
        @(posedge Clock); #2;
        Reset_n = 1'b1;
    endtask

    vec_t tbl[10];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, idx, pc, rw, hi;
        logic [15:0] rin_or;
        logic [4:0]  op_or;
        logic [15:0] r3;

        tbl[0] = '{32'h4A1B8000, 0, 16'h0008, 16'h0010, 5'h09, 1, 0, 0};
        tbl[1] = '{32'h4A1B8000, 3, 16'h0008, 16'h0010, 5'h09, 1, 3, 0};
        tbl[2] = '{32'h781B8000, 0, 16'h0008, 16'h0000, 5'h0F, 1, 0, 1};
        tbl[3] = '{32'h801B8000, 1, 16'h0008, 16'h0000, 5'h10, 1, 1, 1};
        tbl[4] = '{32'h07FFFFFF, 0, 16'h8000, 16'h8000, 5'h00, 1, 0, 0};
        tbl[5] = '{32'h70000000, 2, 16'h0001, 16'h0001, 5'h0E, 1, 2, 0};
        tbl[6] = '{32'hD0000000, 0, 16'h0000, 16'h0000, 5'h00, 1, 0, 0};
        tbl[7] = '{32'hF8000000, 2, 16'h0000, 16'h0000, 5'h00, 1, 2, 0};
        tbl[8] = '{32'h88000000, 0, 16'h0000, 16'h0000, 5'h00, 1, 0, 0};
        tbl[9] = '{32'hC8000000, 1, 16'h0000, 16'h0000, 5'h00, 1, 1, 0};

        bus.Run = 1'b0; bus.Mem_ready = 1'b0; bus.IR = '0;
`ifdef STEP_MODE_EN
        bus.Step = 1'b0;
`endif
        #2;
        do_reset();

        // Directed vectors: key per-instruction observations plus the full per-cycle model.
        foreach (tbl[i]) begin
            model_instr(tbl[i].ir, tbl[i].waits, 1'b1, 1'b0, 1'b0);
            obs.delete();
            play(q.size());
            t0 = 0;
            while (t0 < obs.size() && obs[t0].PCout !== 1'b1) t0++;
            idx = t0 + 3 + tbl[i].waits;
            r3 = (idx < obs.size()) ? obs[idx].Rout : 16'hxxxx;
            rin_or = '0; op_or = '0; pc = 0; rw = 0; hi = 0;
            foreach (obs[k]) begin
                rin_or |= obs[k].Rin;
                op_or  |= obs[k].op;
                pc += int'(obs[k].PCin);
                rw += int'(obs[k].Read & ~obs[k].PCin);
                hi += int'(obs[k].HIin);
            end
            check_val($sformatf("vec%0d_rout_T3", i), r3, tbl[i].r3);
            check_val($sformatf("vec%0d_rin", i), rin_or, tbl[i].rin);
            check_val($sformatf("vec%0d_op", i), op_or, tbl[i].op);
            check_val($sformatf("vec%0d_pcin_cycles", i), pc, tbl[i].pcin);
            check_val($sformatf("vec%0d_wait_cycles", i), rw, tbl[i].rw);
            check_val($sformatf("vec%0d_hiin_cycles", i), hi, tbl[i].hi);
        end

        // Randomized instruction stream with Run wandering mid-instruction.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] ir;
            int cat, op;
            cat = $urandom_range(0, 9);
            if (cat <= 4)      op = $urandom_range(0, 14);
            else if (cat <= 6) op = 15 + $urandom_range(0, 1);
            else if (cat == 7) op = 26;
            else begin
                op = $urandom_range(17, 29);
                if (op >= 26) op = op + 2;
            end
            ir = $urandom;
            ir[31:27] = 5'(op);
            model_instr(ir, $urandom_range(0, 3), $urandom_range(0, 3) != 0, 1'b1, 1'b0);
            play(q.size());
        end

        // Reset while in T4 aborts at once, clears Illegal.
        model_instr(32'hF8000000, 0, 1'b1, 1'b0, 1'b0);
        model_instr(32'h4A1B8000, 0, 1'b1, 1'b0, 1'b0);
        play(q.size() - 2);
        step_cyc(q.pop_front());
        Reset_n = 1'b0;
        #1;
        check_ov("RT4", sample(), '0);
        q.delete(); m_ill = 1'b0; m_idle = 1'b1;
        @(posedge Clock); #2;
        Reset_n = 1'b1;
        push(1'b0, 1'b1, 1'b0, 32'h4A1B8000, base(), "POST");
        play(1);

        // Illegal then halt: Halted held despite Run toggling until reset.
        model_instr(32'hF8000000, 1, 1'b1, 1'b0, 1'b0);
        model_instr(32'hD8000000, 0, 1'b1, 1'b1, 1'b0);
        model_halt(8, 32'hD8000000);
        play(q.size());
        do_reset();
        push(1'b0, 1'b0, 1'b0, 32'h0, base(), "IDLE");
        play(1);

`ifdef STEP_MODE_EN
        // Step held high advances exactly one instruction.
        model_instr(32'hD0000000, 0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) push(1'b1, 1'b1, 1'b1, 32'hD0000000, base(), "HOLD");
        model_instr(32'h4A1B8000, 1, 1'b1, 1'b0, 1'b0);
        play(q.size());
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
